ahb_bridge_arbiter: RTL and testbench
=====================================

// Module: ahb_bridge_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single AHB-to-APB bridge between NM AHB masters.
//  Grants bus ownership, honours locked transfers, and waits for the bridge's hreadyout
//  before handing over. Muxes the owner's address phase and the data-phase master's
//  hwdata onto the bridge inputs. Sits between the masters and the bridge's AHB slave
//  interface.
// PARAMETERS
//  NM       2   number of masters (2..4)
//  MW       1   width of master index, $clog2(NM)
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  16  owner tenure limit in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  hclk       in   1      clock
//  hresetn    in   1      synchronous reset, active-high
//  hbusreq    in   NM     per-master bus request
//  hlock      in   NM     per-master lock request
//  haddr_m    in   NM*AW  concatenated master addresses, master i at [i*AW +: AW]
//  hwdata_m   in   NM*DW  concatenated master write data
//  hwrite_m   in   NM     per-master write flag
//  htrans_m   in   NM*2   per-master htrans
//  hreadyout  in   1      ready from bridge; 1 = current transfer complete
//  hgrant     out  NM     one-hot grant, registered
//  hmaster    out  MW     index of address-phase owner, registered
//  hmastlock  out  1      owner holds a locked tenure
//  haddr      out  AW     haddr_m of hmaster
//  hwrite     out  1      hwrite_m of hmaster
//  htrans     out  2      htrans_m of hmaster; forced 2'b00 (IDLE) when hgrant==0
//  hwdata     out  DW     hwdata_m of data-phase master hmaster_d
//  timeout_o  out  1      one-cycle pulse on forced handover
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, hgrant=0, hmaster=0, hmaster_d=0, hmastlock=0, timeout_o=0,
//   rr pointer last=NM-1 so master 0 wins first. Reset mid-tenure drops the grant
//   in the same edge.
//  Round-robin pick: the first requester scanning last+1, last+2, ... mod NM.
//   last is updated to the winner on every grant.
//  FSM:
//   IDLE:  any hbusreq -> OWN; hgrant/hmaster loaded with winner at that edge (1-cycle
//          latency req->grant). hmastlock<=hlock[winner].
//   OWN:   release = !hbusreq[hmaster] && !hmastlock.
//          release && hreadyout: if another request is pending, grant the next winner
//          this edge (no dead cycle) and stay in OWN; otherwise hgrant<=0 -> IDLE.
//          release && !hreadyout -> DRAIN, grant held.
//          hmastlock clears when hlock[hmaster]=0 && hreadyout=1.
//   DRAIN: hold grant until hreadyout=1, then act as release-with-hreadyout above.
//  Handover happens only on an edge with hreadyout=1. A locked owner never loses the grant.
//  hmaster_d <= hmaster on each edge with hreadyout=1 (AHB pipelined data phase).
//   hwdata is muxed by hmaster_d.
//  Simultaneous: an owner dropping req while others raise req produces a
//   single-edge switch. Requests from non-owners do not disturb the owner.
//  Requesters absent from hbusreq are never granted. hgrant is always one-hot or zero.
//  Output muxes are combinational from registered selects; no arithmetic beyond the
//   pointer mod NM.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - an MW-independent 8-bit tenure counter clears on each grant and increments in OWN.
//   - When count>=TIMEOUT-1, another master requests, !hmastlock and hreadyout=1,
//     the grant is forced to the next winner and timeout_o pulses for 1 cycle.
//   - Counter saturates.
//  ARB_TIMEOUT_EN undefined: no counter; timeout_o tied 0; owner keeps the bus until release.
// TESTING
//  - Reset, then hbusreq=2'b11 -> cycle+1 hgrant=2'b01, hmaster=0; drop req0 with
//    hreadyout=1 -> next edge hgrant=2'b10.
//  - Fairness: hbusreq held 2'b11, each owner releases after 1 transfer -> grants
//    alternate 01,10,01,10.
//  - hlock[0]=1 with hbusreq[0]=0 and req1=1 -> hgrant stays 01 until hlock[0]=0 and
//    hreadyout=1.
//  - Release with hreadyout=0 for 3 cycles -> DRAIN, grant held 3 cycles, switch on the
//    4th edge; hwdata follows hmaster_d.
//  - Assert hresetn mid-OWN -> next edge hgrant=0, htrans=00, hmaster=0.
//  - ARB_TIMEOUT_EN, TIMEOUT=4, req0 held and req1 raised -> grant moves to master 1
//    after 4 owner cycles with a timeout_o pulse; not with hlock[0]=1.

Source files
------------

// File: rtl/ahb_bridge_arbiter_if.sv
// ============================================================================
// Module      : ahb_bridge_arbiter_if
// Description : Bus bundle between the AHB masters, the bridge arbiter and
//               the AHB-to-APB bridge slave port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_bridge_arbiter_if #(
    parameter int NM = 2,
    parameter int MW = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NM-1:0]    hbusreq;
    logic [NM-1:0]    hlock;
    logic [NM*AW-1:0] haddr_m;
    logic [NM*DW-1:0] hwdata_m;
    logic [NM-1:0]    hwrite_m;
    logic [NM*2-1:0]  htrans_m;
    logic             hreadyout;
    logic [NM-1:0]    hgrant;
    logic [MW-1:0]    hmaster;
    logic             hmastlock;
    logic [AW-1:0]    haddr;
    logic             hwrite;
    logic [1:0]       htrans;
    logic [DW-1:0]    hwdata;
    logic             timeout_o;

    modport slave (
        input  hbusreq, hlock, haddr_m, hwdata_m, hwrite_m, htrans_m, hreadyout,
        output hgrant, hmaster, hmastlock, haddr, hwrite, htrans, hwdata, timeout_o
    );

    modport master (
        output hbusreq, hlock, haddr_m, hwdata_m, hwrite_m, htrans_m,
        input  hreadyout, hgrant, hmaster, hmastlock, haddr, hwrite, htrans, hwdata,
               timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/ahb_bridge_arbiter.sv
// ============================================================================
// Module      : ahb_bridge_arbiter
// Description : Round-robin arbiter sharing one AHB-to-APB bridge between NM
//               masters. Optional tenure timeout via macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_bridge_arbiter #(
    parameter int NM      = 2,
    parameter int MW      = 1,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic             hclk,
    input  wire logic             hresetn,
    ahb_bridge_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [NM-1:0] r_grant, w_grant_nxt;
    logic [MW-1:0] r_master, w_master_nxt;
    logic [MW-1:0] r_master_d;
    logic [MW-1:0] r_last, w_last_nxt;
    logic          r_mastlock, w_lock_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          w_found;
    logic [MW-1:0] w_winner;
    logic [MW-1:0] w_sel;
    logic          w_release;
    logic          w_handover;
    logic          w_grant_evt;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_TO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] r_count;
    logic       w_others;
    logic       w_to_hit;

    assign w_others = |(bus.hbusreq & ~r_grant);
    assign w_to_hit = (r_count >= c_TO_LIMIT) && w_others && !r_mastlock && bus.hreadyout;
`endif

    // First requester scanning last+1, last+2, ... wraps so the previous winner is checked last
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sel    = '0;
        for (int k = 1; k <= NM; k++) begin
            w_sel = MW'((int'(r_last) + k) % NM);
            if (!w_found && bus.hbusreq[w_sel]) begin
                w_found  = 1'b1;
                w_winner = w_sel;
            end
        end
    end

    assign w_release = !bus.hbusreq[r_master] && !r_mastlock;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_master_nxt  = r_master;
        w_last_nxt    = r_last;
        w_lock_nxt    = r_mastlock;
        w_timeout_nxt = 1'b0;
        w_handover    = 1'b0;
        w_grant_evt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) w_handover = 1'b1;
            end
            S_OWN: begin
                if (w_release) begin
                    if (bus.hreadyout) w_handover  = 1'b1;
                    else               w_state_nxt = S_DRAIN;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (w_to_hit) begin
                        w_handover    = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end else
`endif
                    if (r_mastlock && !bus.hlock[r_master] && bus.hreadyout) w_lock_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                if (bus.hreadyout) w_handover = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // With no other requester the bus returns to idle instead of re-granting
        if (w_handover) begin
            if (w_found) begin
                w_state_nxt  = S_OWN;
                w_grant_nxt  = NM'(1) << w_winner;
                w_master_nxt = w_winner;
                w_last_nxt   = w_winner;
                w_lock_nxt   = bus.hlock[w_winner];
                w_grant_evt  = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_lock_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_master   <= '0;
            r_master_d <= '0;
            r_last     <= MW'(NM - 1);
            r_mastlock <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_master   <= w_master_nxt;
            r_last     <= w_last_nxt;
            r_mastlock <= w_lock_nxt;
            r_timeout  <= w_timeout_nxt;
            if (bus.hreadyout) r_master_d <= r_master;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_count <= '0;
        end else if (w_grant_evt) begin
            r_count <= '0;
        end else if (r_state == S_OWN && r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end
`endif

    assign bus.hgrant    = r_grant;
    assign bus.hmaster   = r_master;
    assign bus.hmastlock = r_mastlock;
    assign bus.timeout_o = r_timeout;
    assign bus.haddr     = AW'(bus.haddr_m >> (int'(r_master) * AW));
    assign bus.hwrite    = bus.hwrite_m[r_master];
    assign bus.htrans    = (r_grant == '0) ? 2'b00 : 2'(bus.htrans_m >> (int'(r_master) * 2));
    assign bus.hwdata    = DW'(bus.hwdata_m >> (int'(r_master_d) * DW));

endmodule

`default_nettype wire

// File: tb/tb_ahb_bridge_arbiter.sv
// ============================================================================
// Module      : tb_ahb_bridge_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_bridge_arbiter;
    localparam int NM      = 2;
    localparam int MW      = 1;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic hclk = 1'b0;
    logic hresetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 hclk = ~hclk;

    ahb_bridge_arbiter_if #(.NM(NM), .MW(MW), .AW(AW), .DW(DW)) bus ();

    ahb_bridge_arbiter #(.NM(NM), .MW(MW), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    // Behavioural model: owner index (-1 = nobody), rotating priority, pending release
    int m_owner, m_hm, m_last, m_d, m_cnt;
    bit m_lock, m_drain, m_to;

    function automatic int pick(logic [NM-1:0] req, int last);
        for (int k = 1; k <= NM; k++) begin
            if (1'((req >> ((last + k) % NM)) & 1)) return (last + k) % NM;
        end
        return -1;
    endfunction

    function automatic void give(int w);
        m_owner = w;
        m_hm    = w;
        m_last  = w;
        m_lock  = 1'((bus.hlock >> w) & 1);
        m_cnt   = 0;
        m_drain = 0;
    endfunction

    always @(posedge hclk) begin : model
        int w;
        bit rel, others;
        if (hresetn) begin
            m_owner = -1; m_hm = 0; m_last = NM - 1; m_d = 0; m_cnt = 0;
            m_lock = 0; m_drain = 0; m_to = 0;
        end else begin
            if (bus.hreadyout) m_d = m_hm;
            m_to = 0;
            w = pick(bus.hbusreq, m_last);
            if (m_owner < 0) begin
                if (w >= 0) give(w);
            end else begin
                rel    = !1'((bus.hbusreq >> m_owner) & 1) && !m_lock;
                others = (bus.hbusreq & ~(NM'(1) << m_owner)) != '0;
                if (rel || m_drain) begin
                    if (bus.hreadyout) begin
                        if (w >= 0) give(w);
                        else begin m_owner = -1; m_lock = 0; m_drain = 0; end
                    end else m_drain = 1;
                end else if (c_TO_EN && m_cnt >= TIMEOUT - 1 && others && !m_lock && bus.hreadyout) begin
                    give(w);
                    m_to = 1;
                end else begin
                    if (m_lock && !1'((bus.hlock >> m_owner) & 1) && bus.hreadyout) m_lock = 0;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_idle();
        bus.hbusreq   = '0;
        bus.hlock     = '0;
        bus.haddr_m   = {32'hB000_0010, 32'hA000_0004};
        bus.hwdata_m  = {32'hBBBB_0001, 32'hAAAA_0000};
        bus.hwrite_m  = 2'b10;
        bus.htrans_m  = 4'b1010;
        bus.hreadyout = 1'b1;
    endtask

    task automatic do_reset();
        hresetn = 1'b1;
        tick();
        hresetn = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        hresetn = 1'b1;
        tick(); tick();
        n_tests++;
        if ({bus.hgrant, bus.hmaster, bus.hmastlock, bus.timeout_o, bus.htrans} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got grant=%b master=%0d lock=%b to=%b trans=%b, want all 0",
                     bus.hgrant, bus.hmaster, bus.hmastlock, bus.timeout_o, bus.htrans);
        end
        hresetn = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.hbusreq = 2'b11;
        tick();
        n_tests++;
        if (bus.hgrant !== 2'b01 || bus.hmaster !== 1'b0 || bus.htrans !== 2'b10) begin
            n_fail++;
            $display("FAIL first_grant: got grant=%b master=%0d trans=%b, want 01/0/10",
                     bus.hgrant, bus.hmaster, bus.htrans);
        end
        bus.hbusreq = 2'b10;
        tick();
        n_tests++;
        if (bus.hgrant !== 2'b10 || bus.hmaster !== 1'b1 || bus.haddr !== 32'hB000_0010) begin
            n_fail++;
            $display("FAIL switch_grant: got grant=%b master=%0d addr=%h, want 10/1/b0000010",
                     bus.hgrant, bus.hmaster, bus.haddr);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] prev, exp;
        do_reset();
        bus.hbusreq = 2'b11;
        tick();
        prev = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
            bus.hbusreq = ~prev;
            tick();
            n_tests++;
            if (bus.hgrant !== exp) begin
                n_fail++;
                $display("FAIL fairness[%0d]: got grant=%b, want %b", i, bus.hgrant, exp);
            end
            prev = exp;
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus.hbusreq = 2'b01;
        bus.hlock   = 2'b01;
        tick();
        bus.hbusreq = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.hgrant !== 2'b01 || bus.hmastlock !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got grant=%b lock=%b, want 01/1", i, bus.hgrant, bus.hmastlock);
            end
        end
        bus.hlock = 2'b00;
        tick();
        n_tests++;
        if (bus.hmastlock !== 1'b0 || bus.hgrant !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_clear: got grant=%b lock=%b, want 01/0", bus.hgrant, bus.hmastlock);
        end
        tick();
        n_tests++;
        if (bus.hgrant !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_release: got grant=%b, want 10", bus.hgrant);
        end
    endtask

    task automatic test_drain();
        do_reset();
        bus.hbusreq = 2'b01;
        tick(); tick();
        bus.hbusreq   = 2'b10;
        bus.hreadyout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.hgrant !== 2'b01 || bus.hwdata !== 32'hAAAA_0000) begin
                n_fail++;
                $display("FAIL drain_hold[%0d]: got grant=%b wdata=%h, want 01/aaaa0000",
                         i, bus.hgrant, bus.hwdata);
            end
        end
        bus.hreadyout = 1'b1;
        tick();
        n_tests++;
        if (bus.hgrant !== 2'b10 || bus.hwdata !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL drain_switch: got grant=%b wdata=%h, want 10/aaaa0000", bus.hgrant, bus.hwdata);
        end
        tick();
        n_tests++;
        if (bus.hwdata !== 32'hBBBB_0001) begin
            n_fail++;
            $display("FAIL data_phase: got wdata=%h, want bbbb0001", bus.hwdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.hbusreq = 2'b10;
        tick();
        hresetn = 1'b1;
        tick();
        n_tests++;
        if (bus.hgrant !== 2'b00 || bus.htrans !== 2'b00 || bus.hmaster !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got grant=%b trans=%b master=%0d, want 00/00/0",
                     bus.hgrant, bus.htrans, bus.hmaster);
        end
        hresetn = 1'b0;
        bus.hbusreq = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.hbusreq = 2'b11;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (bus.hgrant !== ((i == 4) ? 2'b10 : 2'b01) || bus.timeout_o !== (i == 4)) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got grant=%b to=%b", i, bus.hgrant, bus.timeout_o);
            end
        end
        do_reset();
        bus.hlock = 2'b01;
        tick();
`endif
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (bus.hgrant !== 2'b01 || bus.timeout_o !== 1'b0) begin
                n_fail++;
                $display("FAIL owner_keeps[%0d]: got grant=%b to=%b, want 01/0", i, bus.hgrant, bus.timeout_o);
            end
        end
        bus.hlock = 2'b00;
    endtask

    task automatic test_random();
        logic [NM-1:0] eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0]    et;
        logic          ew;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.hbusreq   = bus.hbusreq ^ NM'($urandom_range(0, 3) == 0 ? $urandom : 0);
            bus.hlock     = NM'($urandom & $urandom);
            bus.hreadyout = ($urandom_range(0, 3) != 0);
            bus.haddr_m   = {$urandom, $urandom};
            bus.hwdata_m  = {$urandom, $urandom};
            bus.hwrite_m  = NM'($urandom);
            bus.htrans_m  = 4'($urandom);
            hresetn       = ($urandom_range(0, 99) == 0);
            tick();
            eg = (m_owner < 0) ? '0 : NM'(1) << m_owner;
            n_tests++;
            if ({bus.hgrant, bus.hmaster, bus.hmastlock, bus.timeout_o} !==
                {eg, MW'(m_hm), m_lock, m_to}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got grant=%b master=%0d lock=%b to=%b, want %b/%0d/%b/%b",
                         c, bus.hgrant, bus.hmaster, bus.hmastlock, bus.timeout_o, eg, m_hm, m_lock, m_to);
            end
            ea = AW'(bus.haddr_m >> (m_hm * AW));
            ed = DW'(bus.hwdata_m >> (m_d * DW));
            ew = 1'((bus.hwrite_m >> m_hm) & 1);
            et = (m_owner < 0) ? 2'b00 : 2'(bus.htrans_m >> (m_hm * 2));
            n_tests++;
            if ({bus.haddr, bus.hwdata, bus.hwrite, bus.htrans} !== {ea, ed, ew, et}) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got addr=%h wdata=%h wr=%b trans=%b, want %h/%h/%b/%b",
                         c, bus.haddr, bus.hwdata, bus.hwrite, bus.htrans, ea, ed, ew, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_lock();
        drive_idle();
        test_drain();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
